// File: rtl/axis_pkt_rr_arbiter_if.sv
// AXI-Stream bundle carrying LANES independent streams packed side by side.
// Lane i data occupies tdata[i*DATA_WIDTH +: DATA_WIDTH]; keep is packed the same way.
interface axis_pkt_rr_arbiter_if #(
  parameter int unsigned LANES      = 1,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

  logic [LANES-1:0]            tvalid;
  logic [LANES-1:0]            tready;
  logic [LANES*DATA_WIDTH-1:0] tdata;
  logic [LANES*KEEP_WIDTH-1:0] tkeep;
  logic [LANES-1:0]            tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-atomic round-robin arbiter: NUM_PORTS AXIS sources share one sink.
// A grant is held until the granted source completes a tlast handshake.
module axis_pkt_rr_arbiter #(
  parameter  int unsigned NUM_PORTS  = 4,
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned GW         = $clog2(NUM_PORTS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_PORTS-1:0]  port_en,
  axis_pkt_rr_arbiter_if.slave  s_axis,
  axis_pkt_rr_arbiter_if.master m_axis,
  output logic                  busy,
  output logic [GW-1:0]         grant_idx,
  output logic [15:0]           pkt_cnt
);

  localparam int unsigned KW = DATA_WIDTH / 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state;
  logic [GW-1:0]        last_grant;
  logic [NUM_PORTS-1:0] req;
  logic                 req_any;
  logic [GW-1:0]        next_grant;
  logic [GW-1:0]        scan_idx;
  logic                 last_hs;
  logic [15:0]          pkt_cnt_nxt;

  // Round-robin pick: first request scanning upward from last_grant+1, modulo NUM_PORTS
  always_comb begin
    req        = s_axis.tvalid & port_en;
    req_any    = 1'b0;
    next_grant = last_grant;
    scan_idx   = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      scan_idx = GW'((32'(last_grant) + i) % NUM_PORTS);
      if (!req_any && req[scan_idx]) begin
        req_any    = 1'b1;
        next_grant = scan_idx;
      end
    end
  end

  // Combinational mux of the granted slice; handshakes only pass while a grant is held
  always_comb begin
    m_axis.tvalid = '0;
    s_axis.tready = '0;
    m_axis.tdata  = s_axis.tdata[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
    m_axis.tkeep  = s_axis.tkeep[32'(grant_idx) * KW +: KW];
    m_axis.tlast  = s_axis.tlast[grant_idx];
    if (state == BUSY) begin
      m_axis.tvalid[0]         = s_axis.tvalid[grant_idx];
      s_axis.tready[grant_idx] = m_axis.tready[0];
    end
  end

  assign last_hs     = m_axis.tvalid[0] & m_axis.tready[0] & m_axis.tlast[0];
  assign pkt_cnt_nxt = pkt_cnt + 16'(last_hs);

  // last_grant resets to the top port so port 0 wins the first arbitration
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      busy       <= 1'b0;
      grant_idx  <= '0;
      last_grant <= GW'(NUM_PORTS - 1);
      pkt_cnt    <= '0;
    end else begin
      pkt_cnt <= pkt_cnt_nxt;
      case (state)
        IDLE: begin
          if (req_any) begin
            state      <= BUSY;
            busy       <= 1'b1;
            grant_idx  <= next_grant;
            last_grant <= next_grant;
          end
        end
        BUSY: begin
          if (last_hs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Randomized and directed bench for axis_pkt_rr_arbiter against a packet-level
// reference model: per-port packet generators, a grant log and a beat log.
module tb_axis_pkt_rr_arbiter;
  localparam int unsigned NP = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned KW = DW / 8;

  logic          clk  = 1'b0;
  logic          rstn = 1'b1;
  logic [NP-1:0] port_en;
  logic          busy;
  logic [1:0]    grant_idx;
  logic [15:0]   pkt_cnt;

  axis_pkt_rr_arbiter_if #(.LANES(NP), .DATA_WIDTH(DW)) s_if ();
  axis_pkt_rr_arbiter_if #(.LANES(1),  .DATA_WIDTH(DW)) m_if ();

  axis_pkt_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .port_en   (port_en),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .busy      (busy),
    .grant_idx (grant_idx),
    .pkt_cnt   (pkt_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Source generators
  bit          vld[NP];
  bit          acc[NP];
  bit          gen_on[NP];
  int          beat[NP];
  int          len[NP];
  int          pkts_left[NP];
  int          fixed_len[NP];
  int          served[NP];
  logic [31:0] base[NP];
  logic [31:0] base_next[NP];
  int          vprob = 100;
  int          rprob = 100;
  logic [NP-1:0] en_cfg = '1;
  bit          rdy_pat[$];

  // Reference model: who owns the sink, who was served last, packets forwarded
  bit          mdl_busy;
  int          mdl_grant;
  int          mdl_last;
  int          mdl_cnt;
  int          grants[$];
  logic [31:0] hs_data[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int grant_at(input int i);
    return (grants.size() > i) ? grants[i] : -1;
  endfunction

  function automatic logic [31:0] hs_at(input int i);
    return (hs_data.size() > i) ? hs_data[i] : 32'hDEAD_BEEF;
  endfunction

  // Advance generators after the previous edge and drive all inputs
  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) begin
        acc[p] = 1'b0;
        vld[p] = 1'b0;
        beat[p]++;
        if (beat[p] == len[p]) begin
          gen_on[p] = 1'b0;
          pkts_left[p]--;
        end
      end
      if (!gen_on[p] && pkts_left[p] > 0) begin
        gen_on[p]    = 1'b1;
        beat[p]      = 0;
        len[p]       = (fixed_len[p] != 0) ? fixed_len[p] : int'($urandom_range(1, 5));
        base[p]      = base_next[p];
        base_next[p] = $urandom;
      end
      if (gen_on[p] && !vld[p] && int'($urandom_range(99)) < vprob) vld[p] = 1'b1;
      s_if.tvalid[p]             = vld[p];
      s_if.tdata[p*DW +: DW]     = base[p] + 32'(beat[p]);
      s_if.tkeep[p*KW +: KW]     = 4'(base[p] + 32'(beat[p]));
      s_if.tlast[p]              = gen_on[p] && (beat[p] == len[p] - 1);
    end
    port_en = en_cfg;
    if (rdy_pat.size() > 0) m_if.tready[0] = rdy_pat.pop_front();
    else                    m_if.tready[0] = (int'($urandom_range(99)) < rprob);
  endtask

  // Compare outputs with the model, then step the model across the coming edge
  task automatic check_update();
    int            g;
    bit            rdy;
    logic [NP-1:0] exp_sr;
    g      = mdl_grant;
    rdy    = m_if.tready[0];
    exp_sr = mdl_busy ? (NP'(rdy) << g) : '0;
    check_eq("busy", busy, mdl_busy);
    check_eq("grant_idx", grant_idx, g);
    check_eq("pkt_cnt", pkt_cnt, mdl_cnt);
    check_eq("m_tvalid", m_if.tvalid, mdl_busy && vld[g]);
    check_eq("s_tready", s_if.tready, exp_sr);
    if (mdl_busy) begin
      check_eq("m_tdata", m_if.tdata, base[g] + 32'(beat[g]));
      check_eq("m_tkeep", m_if.tkeep, 4'(base[g] + 32'(beat[g])));
      check_eq("m_tlast", m_if.tlast, beat[g] == len[g] - 1);
      if (vld[g] && rdy) begin
        acc[g] = 1'b1;
        hs_data.push_back(m_if.tdata);
        if (beat[g] == len[g] - 1) begin
          mdl_busy = 1'b0;
          mdl_cnt  = (mdl_cnt + 1) % 65536;
          served[g]++;
        end
      end
    end else begin
      for (int k = 1; k <= NP; k++) begin
        int c;
        c = (mdl_last + k) % NP;
        if (vld[c] && en_cfg[c]) begin
          mdl_busy  = 1'b1;
          mdl_grant = c;
          mdl_last  = c;
          grants.push_back(c);
          break;
        end
      end
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      check_update();
    end
  endtask

  function automatic bit all_idle();
    bit r;
    r = !mdl_busy;
    for (int p = 0; p < NP; p++) if (pkts_left[p] != 0 || gen_on[p]) r = 1'b0;
    return r;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      run_cycles(1);
      n++;
    end
    check_eq(tag, all_idle(), 1'b1);
  endtask

  task automatic clear_logs();
    grants.delete();
    hs_data.delete();
    for (int p = 0; p < NP; p++) served[p] = 0;
  endtask

  // Asynchronous reset asserted mid low phase; outputs must clear without a clock edge
  task automatic do_reset();
    #2;
    rstn = 1'b0;
    for (int p = 0; p < NP; p++) begin
      vld[p] = 1'b0; acc[p] = 1'b0; gen_on[p] = 1'b0; pkts_left[p] = 0; fixed_len[p] = 0;
    end
    s_if.tvalid = '0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = '0;
    m_if.tready = 1'b1;
    #1;
    check_eq("rst_m_tvalid", m_if.tvalid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_pkt_cnt", pkt_cnt, 16'h0);
    check_eq("rst_grant_idx", grant_idx, 2'd0);
    check_eq("rst_s_tready", s_if.tready, '0);
    mdl_busy = 1'b0; mdl_grant = 0; mdl_last = NP - 1; mdl_cnt = 0;
    rdy_pat.delete();
    clear_logs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int total;
    port_en = '1;
    m_if.tready = 1'b1;
    do_reset();

    // Single source: port 2, three beats 0xA0..0xA2
    vprob = 100; rprob = 100;
    base_next[2] = 32'hA0; fixed_len[2] = 3; pkts_left[2] = 1;
    drain("t1_drain", 20);
    check_eq("t1_grant", grant_at(0), 2);
    check_eq("t1_beat0", hs_at(0), 32'hA0);
    check_eq("t1_beat1", hs_at(1), 32'hA1);
    check_eq("t1_beat2", hs_at(2), 32'hA2);
    check_eq("t1_cnt", pkt_cnt, 16'd1);

    // All four ports continuously sending 2-beat packets
    do_reset();
    for (int p = 0; p < NP; p++) begin fixed_len[p] = 2; pkts_left[p] = 2; end
    drain("t2_drain", 60);
    for (int i = 0; i < 8; i++) check_eq("t2_order", grant_at(i), i % NP);
    for (int p = 0; p < NP; p++) check_eq("t2_served", served[p], 2);
    check_eq("t2_cnt", pkt_cnt, 16'd8);

    // Backpressure on a 4-beat packet from port 1
    clear_logs();
    base_next[1] = 32'h100; fixed_len[1] = 4; pkts_left[1] = 1;
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    drain("t3_drain", 30);
    check_eq("t3_nhs", hs_data.size(), 4);
    for (int i = 0; i < 4; i++) check_eq("t3_data", hs_at(i), 32'h100 + 32'(i));

    // Grant lock: port 0 keeps the grant after its enable drops; port 3 goes next
    clear_logs();
    fixed_len[0] = 4; pkts_left[0] = 2;
    run_cycles(2);
    en_cfg[0] = 1'b0;
    fixed_len[3] = 2; pkts_left[3] = 1;
    run_cycles(20);
    check_eq("t4_ngrants", grants.size(), 2);
    check_eq("t4_first", grant_at(0), 0);
    check_eq("t4_second", grant_at(1), 3);
    check_eq("t4_served0", served[0], 1);
    en_cfg = '1;
    drain("t4_drain", 30);
    check_eq("t4_third", grant_at(2), 0);

    // Reset in the middle of a 5-beat packet from port 1
    clear_logs();
    fixed_len[1] = 5; pkts_left[1] = 1;
    run_cycles(3);
    check_eq("t5_pre_tvalid", m_if.tvalid, 1'b1);
    do_reset();
    fixed_len[0] = 2; pkts_left[0] = 1;
    fixed_len[1] = 2; pkts_left[1] = 1;
    drain("t5_drain", 20);
    check_eq("t5_first", grant_at(0), 0);
    check_eq("t5_second", grant_at(1), 1);

    // Packet counter wrap from 0xFFFF
    force dut.pkt_cnt = 16'hFFFF;
    mdl_cnt = 65535;
    run_cycles(1);
    release dut.pkt_cnt;
    run_cycles(1);
    fixed_len[2] = 1; pkts_left[2] = 1;
    drain("t6_drain", 10);
    check_eq("t6_wrap", pkt_cnt, 16'h0000);

    // Random traffic, lengths, backpressure and enable changes
    do_reset();
    vprob = 60; rprob = 70; total = 0;
    for (int p = 0; p < NP; p++) begin
      fixed_len[p] = 0;
      pkts_left[p] = int'($urandom_range(5, 25));
      total += pkts_left[p];
    end
    for (int b = 0; b < 40; b++) begin
      en_cfg = NP'($urandom);
      run_cycles(50);
    end
    en_cfg = '1;
    drain("t7_drain", 3000);
    check_eq("t7_cnt", pkt_cnt, 16'(total));
    check_eq("t7_served", served[0] + served[1] + served[2] + served[3], total);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
